// File: rtl/vx_cache_evict_buffer_if.sv
// Line-transfer bus: a line address, line data and a byte mask under valid/ready.
// No latency; this is wiring only.
// The receiver holds off the sender by deasserting ready. The payload must stay stable while valid is high and ready is low.
interface vx_cache_evict_buffer_if #(
    parameter int LINE_SIZE       = 16,
    parameter int LINE_ADDR_WIDTH = 26
);
    logic                       valid;
    logic                       ready;
    logic [LINE_ADDR_WIDTH-1:0] addr;
    logic [8*LINE_SIZE-1:0]     data;
    logic [LINE_SIZE-1:0]       byteen;

    // Producer of a line transfer
    modport master (
        output valid,
        output addr,
        output data,
        output byteen,
        input  ready
    );

    // Consumer of a line transfer
    modport slave (
        input  valid,
        input  addr,
        input  data,
        input  byteen,
        output ready
    );
endinterface

// File: rtl/vx_cache_evict_buffer.sv
// Writeback eviction buffer: queues dirty victim lines in order and issues them as memory writes.
// Latency: an accepted line shows up as a memory request one cycle later. There is no same-cycle bypass.
// Backpressure: evict ready is simply !full, from registered state only. A stalled memory request holds its payload stable.
module vx_cache_evict_buffer #(
    parameter int LINE_SIZE       = 16,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int DEPTH           = 4      // power of two, >= 2
) (
    input  logic                          clk,
    input  logic                          reset,        // async, active low
    vx_cache_evict_buffer_if.slave        evict,
    vx_cache_evict_buffer_if.master       mem_req,
    input  logic [LINE_ADDR_WIDTH-1:0]    lookup_addr,
    output logic                          lookup_hit,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [LINE_ADDR_WIDTH-1:0] addr;
        logic [8*LINE_SIZE-1:0]     data;
        logic [LINE_SIZE-1:0]       byteen;
    } entry_t;

    // Payload storage is deliberately not reset; the valid bits and the count qualify it.
    entry_t             entries [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic               full;
    logic               is_empty;
    logic               evict_fire;
    logic               enq_store;
    logic               deq;
    entry_t             head;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign is_empty  = (count_q == '0);

    // Clean victims (all-zero mask) complete the handshake but are never stored.
    assign evict_fire = evict.valid & evict.ready;
    assign enq_store  = evict_fire & (|evict.byteen);
    assign deq        = mem_req.valid & mem_req.ready;

    assign evict.ready = !full;

    // The head entry drives the memory side directly, so the payload is stable while the request is stalled.
    assign head           = entries[rd_ptr];
    assign mem_req.valid  = !is_empty;
    assign mem_req.addr   = head.addr;
    assign mem_req.data   = head.data;
    assign mem_req.byteen = head.byteen;

    assign empty = is_empty;
    assign count = count_q;

    // Pointer and occupancy bookkeeping. Reset drops every pending line at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq_store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_store, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Per-entry valid bits that feed the address-hit search.
    // The write slot and the read slot never coincide on a cycle when both fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (deq && (rd_ptr == PTR_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (enq_store && (wr_ptr == PTR_W'(i))) begin
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    // Capture the victim line into the tail slot.
    always_ff @(posedge clk) begin
        if (enq_store) begin
            entries[wr_ptr] <= '{addr: evict.addr, data: evict.data, byteen: evict.byteen};
        end
    end

    // Hit against registered entries only.
    // A line being written this cycle is not visible yet. A line leaving this cycle still hits.
    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entries[i].addr == lookup_addr)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    // Protocol invariants
    a_no_enq_full : assert property (@(posedge clk) disable iff (!reset) enq_store |-> !full);
    a_no_deq_empty: assert property (@(posedge clk) disable iff (!reset) deq |-> !is_empty);
    a_head_valid  : assert property (@(posedge clk) disable iff (!reset) !is_empty |-> valid_q[rd_ptr]);
    a_byteen_nz   : assert property (@(posedge clk) disable iff (!reset) !is_empty |-> (head.byteen != '0));
    a_count_bound : assert property (@(posedge clk) disable iff (!reset) count_q <= CNT_W'(DEPTH));

endmodule
